angle_greater_fp: RTL and testbench
===================================

ANGLE_GREATER_FP -- requirements
Module: angle_greater_fp

Interface
REQ-001 Parameter: LATENCY, default 1, number of register stages from input to output; legal values 1 or 2.
REQ-002 Clocking and reset SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: in_valid  input  1  operands a and b are valid this cycle.
REQ-006 Port: a  input  32  IEEE-754 single-precision operand A (sign[31], exp[30:23], mant[22:0]).
REQ-007 Port: b  input  32  IEEE-754 single-precision operand B.
REQ-008 Port: out_valid  output  1  result outputs are valid this cycle.
REQ-009 Port: a_gt_b  output  1  A is strictly greater than B.
REQ-010 Port: a_eq_b  output  1  A and B are bit-identical.
REQ-011 Port: unordered  output  1  at least one operand is NaN; only driven when the NaN feature is enabled (REQ-030), otherwise constant 0.

Function
REQ-012 The block SHALL use a sign-magnitude total order on raw bits; +0 and -0 are distinct.
- Signs differ: a_gt_b = NOT a[31], so +0 (0x00000000) > -0 (0x80000000).
- Both positive: a_gt_b = (a[30:0] > b[30:0]) unsigned.
- Both negative: a_gt_b = (a[30:0] < b[30:0]) unsigned.
REQ-013 a_eq_b SHALL be 1 iff a == b over all 32 bits; when a_eq_b is 1, a_gt_b SHALL be 0.
REQ-014 The exponent field SHALL dominate the mantissa (this follows from the 31-bit magnitude compare); denormals SHALL be ordered by raw bits with no flushing.
REQ-015 Infinities SHALL be ordered as the largest magnitudes: +Inf is greater than every finite positive value, and -Inf is less than every finite negative value.
REQ-016 Results for inputs sampled with in_valid=1 SHALL appear exactly LATENCY cycles later with out_valid=1.
REQ-017 The pipeline SHALL be fully pipelined, accept one operand pair per cycle, and have no backpressure.
REQ-018 When LATENCY=2:
- stage 1 registers the sign, sign-difference, magnitude-greater and magnitude-equal terms;
- stage 2 registers the final outputs.
REQ-019 out_valid SHALL be in_valid delayed by LATENCY cycles.
REQ-020 Result outputs SHALL hold their last value when out_valid=0.
REQ-021 Back-to-back valid inputs SHALL produce back-to-back results in order.

Reset
REQ-022 Asserting rst_n=0 SHALL immediately, asynchronously, clear out_valid, a_gt_b, a_eq_b, unordered and all pipeline valid bits to 0.
REQ-023 Reset asserted while an operation is in the pipeline SHALL discard that operation; no out_valid SHALL appear for it.
REQ-024 After rst_n deasserts, the first in_valid SHALL be honored on the first rising edge.

Configuration
REQ-030 The feature SHALL be controlled by the macro ANGLE_GREATER_NAN_EN.
- Defined: an operand with exp == 0xFF and mant != 0 is NaN. If either operand is NaN, then unordered=1, a_gt_b=0 and a_eq_b=0.
- Undefined: NaNs SHALL be compared by raw bits per REQ-012/013, and unordered SHALL be constant 0.

Verification
REQ-040 a=0x00000000, b=0x00000000 -> a_gt_b=0, a_eq_b=1.
REQ-041 a=0x00000000, b=0x80000000 -> a_gt_b=1, a_eq_b=0; swapped operands -> a_gt_b=0.
REQ-042 a=0xBF800000 (-1.0), b=0xC0000000 (-2.0) -> a_gt_b=1.
REQ-043 Magnitude ordering checks:
- a=0x3F800001, b=0x3F800000 -> a_gt_b=1.
- a=0x3C700000, b=0x3F800000 -> a_gt_b=0.
- a=0x7F800000 (+Inf), b=0x461C4000 -> a_gt_b=1.
REQ-044 NaN check, a=0x7FC00000, b=0x3F800000:
- with ANGLE_GREATER_NAN_EN -> unordered=1, a_gt_b=0;
- without it -> a_gt_b=1.
REQ-045 Pipeline check, for each LATENCY value:
- stream 4 valid pairs back-to-back -> results arrive in order exactly LATENCY cycles after input;
- assert rst_n mid-stream -> out_valid=0 immediately, with no stale results after release.

Source files
------------

// File: rtl/angle_greater_fp.sv
// ============================================================================
// angle_greater_fp : pipelined sign-magnitude total-order compare of two
// IEEE-754 singles. Optional NaN detection via macro ANGLE_GREATER_NAN_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module angle_greater_fp #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic        a_gt_b,
  output logic        a_eq_b,
  output logic        unordered
);

  logic t_sign;
  logic t_diff;
  logic t_gt;
  logic t_eq;
  logic t_nan;

  always_comb begin
    t_sign = a[31];
    t_diff = a[31] ^ b[31];
    t_gt   = (a[30:0] > b[30:0]);
    t_eq   = (a[30:0] == b[30:0]);
  end

`ifdef ANGLE_GREATER_NAN_EN
  logic nan_a;
  logic nan_b;

  always_comb begin
    nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    t_nan = nan_a | nan_b;
  end
`else
  assign t_nan = 1'b0;
`endif

  logic st_valid;
  logic st_sign;
  logic st_diff;
  logic st_gt;
  logic st_eq;
  logic st_nan;

  generate
    if (LATENCY == 2) begin : g_lat2
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          st_valid <= 1'b0;
          st_sign  <= 1'b0;
          st_diff  <= 1'b0;
          st_gt    <= 1'b0;
          st_eq    <= 1'b0;
          st_nan   <= 1'b0;
        end else begin
          st_valid <= in_valid;
          if (in_valid) begin
            st_sign <= t_sign;
            st_diff <= t_diff;
            st_gt   <= t_gt;
            st_eq   <= t_eq;
            st_nan  <= t_nan;
          end
        end
      end
    end else begin : g_lat1
      always_comb begin
        st_valid = in_valid;
        st_sign  = t_sign;
        st_diff  = t_diff;
        st_gt    = t_gt;
        st_eq    = t_eq;
        st_nan   = t_nan;
      end
    end
  endgenerate

  logic res_gt;
  logic res_eq;

  // Negative operands invert the magnitude order; equal magnitudes are never greater.
  always_comb begin
    res_gt = 1'b0;
    res_eq = 1'b0;
    if (!st_nan) begin
      res_eq = !st_diff && st_eq;
      if (st_diff)
        res_gt = !st_sign;
      else if (st_sign)
        res_gt = !st_gt && !st_eq;
      else
        res_gt = st_gt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      a_gt_b    <= 1'b0;
      a_eq_b    <= 1'b0;
    end else begin
      out_valid <= st_valid;
      if (st_valid) begin
        a_gt_b <= res_gt;
        a_eq_b <= res_eq;
      end
    end
  end

`ifdef ANGLE_GREATER_NAN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      unordered <= 1'b0;
    else if (st_valid)
      unordered <= st_nan;
  end
`else
  assign unordered = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_angle_greater_fp.sv
// ============================================================================
// tb_angle_greater_fp : directed checks of angle_greater_fp at LATENCY 1 and 2.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_angle_greater_fp;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;

  logic d1_valid, d1_gt, d1_eq, d1_uno;
  logic d2_valid, d2_gt, d2_eq, d2_uno;

  int errors = 0;
  int checks = 0;

`ifdef ANGLE_GREATER_NAN_EN
  localparam bit NAN_EN = 1'b1;
`else
  localparam bit NAN_EN = 1'b0;
`endif

  angle_greater_fp #(.LATENCY(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(d1_valid), .a_gt_b(d1_gt), .a_eq_b(d1_eq), .unordered(d1_uno)
  );

  angle_greater_fp #(.LATENCY(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(d2_valid), .a_gt_b(d2_gt), .a_eq_b(d2_eq), .unordered(d2_uno)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated operation, checked on both pipeline depths.
  task automatic vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                     input logic egt, input logic eeq, input logic euno);
    @(negedge clk);
    a = va; b = vb; in_valid = 1'b1;
    @(posedge clk); #1;
    chk({tag, " d1.valid"}, {31'd0, d1_valid}, 32'd1);
    chk({tag, " d1.gt"},    {31'd0, d1_gt},    {31'd0, egt});
    chk({tag, " d1.eq"},    {31'd0, d1_eq},    {31'd0, eeq});
    chk({tag, " d1.uno"},   {31'd0, d1_uno},   {31'd0, euno});
    chk({tag, " d2.early"}, {31'd0, d2_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    a = 32'h0; b = 32'h0;
    @(posedge clk); #1;
    chk({tag, " d2.valid"}, {31'd0, d2_valid}, 32'd1);
    chk({tag, " d2.gt"},    {31'd0, d2_gt},    {31'd0, egt});
    chk({tag, " d2.eq"},    {31'd0, d2_eq},    {31'd0, eeq});
    chk({tag, " d2.uno"},   {31'd0, d2_uno},   {31'd0, euno});
    chk({tag, " d1.idle"},  {31'd0, d1_valid}, 32'd0);
    chk({tag, " d1.hold"},  {31'd0, d1_gt},    {31'd0, egt});
  endtask

  logic [31:0] sa  [4];
  logic [31:0] sb  [4];
  logic        sgt [4];
  logic        seq [4];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = 32'h0; b = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset d1", {28'd0, d1_valid, d1_gt, d1_eq, d1_uno}, 32'd0);
    chk("reset d2", {28'd0, d2_valid, d2_gt, d2_eq, d2_uno}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vec("pz_pz",     32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0);
    vec("pz_nz",     32'h00000000, 32'h80000000, 1'b1, 1'b0, 1'b0);
    vec("nz_pz",     32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b0);
    vec("m1_m2",     32'hBF800000, 32'hC0000000, 1'b1, 1'b0, 1'b0);
    vec("ulp",       32'h3F800001, 32'h3F800000, 1'b1, 1'b0, 1'b0);
    vec("small",     32'h3C700000, 32'h3F800000, 1'b0, 1'b0, 1'b0);
    vec("pinf",      32'h7F800000, 32'h461C4000, 1'b1, 1'b0, 1'b0);
    vec("ninf",      32'hFF800000, 32'hC61C4000, 1'b0, 1'b0, 1'b0);
    vec("denorm",    32'h00000002, 32'h00000001, 1'b1, 1'b0, 1'b0);
    vec("negden",    32'h80000001, 32'h80000002, 1'b1, 1'b0, 1'b0);
    vec("nz_nz",     32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b0);
    vec("neg_eqmag", 32'hC0000000, 32'hC0000000, 1'b0, 1'b1, 1'b0);
    vec("nan_one",   32'h7FC00000, 32'h3F800000, !NAN_EN, 1'b0, NAN_EN);
    vec("nan_same",  32'h7FC00000, 32'h7FC00000, 1'b0, !NAN_EN, NAN_EN);

    // Back-to-back stream of four operand pairs.
    sa[0] = 32'h3F800000; sb[0] = 32'h3F7FFFFF; sgt[0] = 1'b1; seq[0] = 1'b0;
    sa[1] = 32'hBF800000; sb[1] = 32'h3F800000; sgt[1] = 1'b0; seq[1] = 1'b0;
    sa[2] = 32'h40000000; sb[2] = 32'h40000000; sgt[2] = 1'b0; seq[2] = 1'b1;
    sa[3] = 32'h00000000; sb[3] = 32'h80000001; sgt[3] = 1'b1; seq[3] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = (c < 4);
      a = (c < 4) ? sa[c] : 32'h0;
      b = (c < 4) ? sb[c] : 32'h0;
      @(posedge clk); #1;
      chk($sformatf("stream%0d d1.valid", c), {31'd0, d1_valid}, {31'd0, (c < 4)});
      if (c < 4) begin
        chk($sformatf("stream%0d d1.gt", c), {31'd0, d1_gt}, {31'd0, sgt[c]});
        chk($sformatf("stream%0d d1.eq", c), {31'd0, d1_eq}, {31'd0, seq[c]});
      end
      chk($sformatf("stream%0d d2.valid", c), {31'd0, d2_valid}, {31'd0, (c >= 1 && c < 5)});
      if (c >= 1 && c < 5) begin
        chk($sformatf("stream%0d d2.gt", c), {31'd0, d2_gt}, {31'd0, sgt[c-1]});
        chk($sformatf("stream%0d d2.eq", c), {31'd0, d2_eq}, {31'd0, seq[c-1]});
      end
    end

    // Reset asserted mid-stream: in-flight results must vanish.
    @(negedge clk);
    in_valid = 1'b1; a = 32'h40000000; b = 32'h3F800000;
    @(posedge clk); #1;
    @(negedge clk);
    a = 32'h7F800000; b = 32'h00000000;
    @(posedge clk); #2;
    chk("pre_rst d1.valid", {31'd0, d1_valid}, 32'd1);
    chk("pre_rst d2.valid", {31'd0, d2_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst d1", {28'd0, d1_valid, d1_gt, d1_eq, d1_uno}, 32'd0);
    chk("async_rst d2", {28'd0, d2_valid, d2_gt, d2_eq, d2_uno}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst%0d d1.valid", c), {31'd0, d1_valid}, 32'd0);
      chk($sformatf("post_rst%0d d2.valid", c), {31'd0, d2_valid}, 32'd0);
    end

    vec("after_rst", 32'hC0000000, 32'hBF800000, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
